// File: rtl/pudiannao_pkg.sv
// Shared types and sizing for the output-buffer feed path.
package pudiannao_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned LANES     = 16;
    localparam int unsigned ROW_WORDS = 256;
    localparam int unsigned BEATS     = ROW_WORDS / LANES;
    localparam int unsigned OB_DEPTH  = 64;
    localparam int unsigned OB_IDX_W  = $clog2(OB_DEPTH);
    localparam int unsigned BEAT_W    = $clog2(BEATS);
    localparam int unsigned LANE_W    = $clog2(LANES);

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic {
        FILL  = 1'b0,
        WRITE = 1'b1
    } pk_state_t;

endpackage

// File: rtl/output_row_packer.sv
// Packs 16-lane MLU result beats into 256-word rows and issues one-cycle row
// writes to the output buffer, tracking the row index and buffer fullness.
module output_row_packer
    import pudiannao_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               res_valid,
    output logic                               res_ready,
    input  word_t [LANES-1:0]                  res_data,
    input  logic                               flush,
    input  logic                               idx_clr,
    input  logic                               wr_hold,
    output word_t [ROW_WORDS-1:0]              buf_in,
    output logic  [OB_IDX_W-1:0]               buf_idx,
    output logic                               buf_write_en,
    output logic  [OB_IDX_W:0]                 row_cnt,
    output logic                               buf_full
);

    pk_state_t               state_q, state_d;
    logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [OB_IDX_W-1:0]     idx_q, idx_d;
    logic [OB_IDX_W:0]       row_cnt_q, row_cnt_d;
    word_t [ROW_WORDS-1:0]   row_q, row_d;

    logic accept;
    logic last_beat;

    assign buf_full     = (row_cnt_q == (OB_IDX_W+1)'(OB_DEPTH));
    assign res_ready    = (state_q == FILL) && !buf_full && !idx_clr;
    assign accept       = res_valid && res_ready;
    assign last_beat    = accept && (beat_cnt_q == BEAT_W'(BEATS - 1));
    assign buf_write_en = (state_q == WRITE) && !wr_hold && !idx_clr;

    assign buf_in  = row_q;
    assign buf_idx = idx_q;
    assign row_cnt = row_cnt_q;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        idx_d      = idx_q;
        row_cnt_d  = row_cnt_q;
        row_d      = row_q;
        if (idx_clr) begin
            state_d    = FILL;
            beat_cnt_d = '0;
            idx_d      = '0;
            row_cnt_d  = '0;
            row_d      = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        for (int unsigned l = 0; l < LANES; l++) begin
                            row_d[{beat_cnt_q, LANE_W'(l)}] = res_data[l];
                        end
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end
                    // A beat arriving with flush is packed first; flush only closes a non-empty row.
                    if (last_beat || (flush && (accept || beat_cnt_q != '0))) begin
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    if (!wr_hold) begin
                        state_d    = FILL;
                        beat_cnt_d = '0;
                        idx_d      = idx_q + OB_IDX_W'(1);
                        row_cnt_d  = row_cnt_q + (OB_IDX_W+1)'(1);
                        row_d      = '0;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FILL;
            beat_cnt_q <= '0;
            idx_q      <= '0;
            row_cnt_q  <= '0;
            row_q      <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            idx_q      <= idx_d;
            row_cnt_q  <= row_cnt_d;
            row_q      <= row_d;
        end
    end

endmodule

// File: tb/tb_output_row_packer.sv
// Self-checking bench for output_row_packer: directed sequences, a vector table
// and a randomized run compared cycle by cycle against a word-level model.
module tb_output_row_packer;
    import pudiannao_pkg::*;

    typedef word_t [LANES-1:0] beat_t;

    logic                  clk;
    logic                  rst;
    logic                  res_valid;
    logic                  res_ready;
    beat_t                 res_data;
    logic                  flush;
    logic                  idx_clr;
    logic                  wr_hold;
    word_t [ROW_WORDS-1:0] buf_in;
    logic  [OB_IDX_W-1:0]  buf_idx;
    logic                  buf_write_en;
    logic  [OB_IDX_W:0]    row_cnt;
    logic                  buf_full;

    output_row_packer dut (
        .clk          (clk),
        .rst          (rst),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .flush        (flush),
        .idx_clr      (idx_clr),
        .wr_hold      (wr_hold),
        .buf_in       (buf_in),
        .buf_idx      (buf_idx),
        .buf_write_en (buf_write_en),
        .row_cnt      (row_cnt),
        .buf_full     (buf_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the row being assembled as a word list plus bookkeeping.
    word_t m_words [ROW_WORDS];
    int    m_nbeats;
    bit    m_pending;
    int    m_idx;
    int    m_rows;

    // Output samples of the most recent cycle.
    logic                  s_ready, s_we, s_full;
    logic [OB_IDX_W-1:0]   s_idx;
    logic [OB_IDX_W:0]     s_rows;
    word_t [ROW_WORDS-1:0] s_row;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_row(input string name);
        int bad;
        bad = -1;
        for (int w = 0; w < ROW_WORDS; w++) begin
            if (bad < 0 && buf_in[w] !== m_words[w]) bad = w;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: word %0d got %0h expected %0h at %0t",
                     name, bad, buf_in[bad], m_words[bad], $time);
        end
    endtask

    task automatic model_clear();
        for (int w = 0; w < ROW_WORDS; w++) m_words[w] = '0;
        m_nbeats  = 0;
        m_pending = 0;
        m_idx     = 0;
        m_rows    = 0;
    endtask

    function automatic beat_t pat(input int b, input int off);
        beat_t r;
        for (int l = 0; l < LANES; l++) r[l] = {16'(b + off), 16'(l)};
        return r;
    endfunction

    function automatic beat_t rnd_beat();
        beat_t r;
        for (int l = 0; l < LANES; l++) r[l] = $urandom;
        return r;
    endfunction

    // One clock cycle: drive, check against model, advance model, cross the edge.
    task automatic cycle(input bit v, input beat_t d, input bit fl, input bit clr, input bit hold);
        bit e_full, e_ready, e_we;
        res_valid = v;
        res_data  = d;
        flush     = fl;
        idx_clr   = clr;
        wr_hold   = hold;
        #2;
        e_full  = (m_rows == OB_DEPTH);
        e_ready = !m_pending && !e_full && !clr;
        e_we    = m_pending && !hold && !clr;
        s_ready = res_ready;
        s_we    = buf_write_en;
        s_full  = buf_full;
        s_idx   = buf_idx;
        s_rows  = row_cnt;
        s_row   = buf_in;
        chk("res_ready", res_ready, e_ready);
        chk("buf_write_en", buf_write_en, e_we);
        chk("buf_full", buf_full, e_full);
        chk("buf_idx", buf_idx, m_idx);
        chk("row_cnt", row_cnt, m_rows);
        chk_row("buf_in");
        if (clr) begin
            model_clear();
        end else if (m_pending) begin
            if (!hold) begin
                m_idx  = (m_idx + 1) % OB_DEPTH;
                m_rows = m_rows + 1;
                for (int w = 0; w < ROW_WORDS; w++) m_words[w] = '0;
                m_nbeats  = 0;
                m_pending = 0;
            end
        end else begin
            if (v && e_ready) begin
                for (int l = 0; l < LANES; l++) m_words[m_nbeats * LANES + l] = d[l];
                m_nbeats++;
            end
            if (m_nbeats == BEATS || (fl && m_nbeats > 0)) m_pending = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        res_valid = 0;
        flush     = 0;
        idx_clr   = 0;
        wr_hold   = 0;
        rst       = 0;
        #2;
        model_clear();
        chk("rst_write_en", buf_write_en, 0);
        chk("rst_idx", buf_idx, 0);
        chk("rst_row_cnt", row_cnt, 0);
        chk("rst_full", buf_full, 0);
        chk_row("rst_buf_in");
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    typedef struct {
        bit v, fl, clr, hold;
        bit ready, we;
        int idx, rows;
    } vec_t;

    vec_t vt [16];
    beat_t zb;
    word_t [ROW_WORDS-1:0] held;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{1, 0, 0, 0, 1, 0, 0, 0};
        vt[1]  = '{1, 1, 0, 0, 1, 0, 0, 0};
        vt[2]  = '{1, 0, 0, 0, 0, 1, 0, 0};
        vt[3]  = '{0, 1, 0, 0, 1, 0, 1, 1};
        vt[4]  = '{0, 0, 0, 0, 1, 0, 1, 1};
        vt[5]  = '{1, 0, 0, 0, 1, 0, 1, 1};
        vt[6]  = '{0, 1, 0, 0, 1, 0, 1, 1};
        vt[7]  = '{0, 0, 0, 1, 0, 0, 1, 1};
        vt[8]  = '{0, 1, 0, 1, 0, 0, 1, 1};
        vt[9]  = '{0, 0, 1, 0, 0, 0, 1, 1};
        vt[10] = '{0, 0, 0, 0, 1, 0, 0, 0};
        vt[11] = '{1, 1, 0, 0, 1, 0, 0, 0};
        vt[12] = '{0, 0, 1, 0, 0, 0, 0, 0};
        vt[13] = '{0, 0, 0, 0, 1, 0, 0, 0};
        vt[14] = '{1, 1, 0, 0, 1, 0, 0, 0};
        vt[15] = '{0, 0, 0, 0, 0, 1, 0, 0};

        zb = '0;
        res_data = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Reset in the middle of a row.
        for (int b = 0; b < 7; b++) cycle(1, pat(b, 32), 0, 0, 0);
        do_reset();
        cycle(0, zb, 0, 0, 0);
        chk("ready_after_reset", s_ready, 1);

        // 16 back-to-back beats.
        for (int b = 0; b < BEATS; b++) begin
            cycle(1, pat(b, 0), 0, 0, 0);
            chk("no_early_we", s_we, 0);
        end
        cycle(0, zb, 0, 0, 0);
        chk("row_we", s_we, 1);
        chk("row_idx", s_idx, 0);
        chk("row_ready_low", s_ready, 0);
        chk("row_first_word", s_row[0], 32'h0000_0000);
        chk("row_word_83", s_row[5*16+3], 32'h0005_0003);
        chk("row_last_word", s_row[255], 32'h000F_000F);
        cycle(0, zb, 0, 0, 0);
        chk("after_row_idx", s_idx, 1);
        chk("after_row_cnt", s_rows, 1);

        // Partial row of 5 beats closed by flush.
        cycle(0, zb, 0, 1, 0);
        for (int b = 0; b < 5; b++) cycle(1, pat(b, 16), 0, 0, 0);
        cycle(0, zb, 1, 0, 0);
        cycle(0, zb, 0, 0, 0);
        chk("flush_we", s_we, 1);
        chk("flush_idx", s_idx, 0);
        chk("flush_word_79", s_row[79], 32'h0014_000F);
        chk("flush_word_80", s_row[80], 32'h0);
        chk("flush_word_255", s_row[255], 32'h0);
        for (int b = 0; b < BEATS; b++) cycle(1, pat(b, 64), 0, 0, 0);
        cycle(0, zb, 0, 0, 0);
        chk("post_flush_we", s_we, 1);
        chk("post_flush_idx", s_idx, 1);
        chk("post_flush_word_80", s_row[80], 32'h0045_0000);

        // Write held off for 4 cycles.
        for (int b = 0; b < BEATS; b++) cycle(1, pat(b, 96), 0, 0, 0);
        held = buf_in;
        for (int i = 0; i < 4; i++) begin
            cycle(1, pat(i, 200), 0, 0, 1);
            chk("hold_no_we", s_we, 0);
            chk("hold_ready_low", s_ready, 0);
            chk("hold_row_stable", s_row === held, 1);
        end
        cycle(0, zb, 0, 0, 0);
        chk("hold_release_we", s_we, 1);
        chk("hold_release_idx", s_idx, 2);

        // Flush / idx_clr corner vectors from a clean start.
        cycle(0, zb, 0, 1, 0);
        for (int i = 0; i < 16; i++) begin
            cycle(vt[i].v, rnd_beat(), vt[i].fl, vt[i].clr, vt[i].hold);
            chk("vec_ready", s_ready, vt[i].ready);
            chk("vec_we", s_we, vt[i].we);
            chk("vec_idx", s_idx, vt[i].idx);
            chk("vec_rows", s_rows, vt[i].rows);
        end

        // Fill all 64 rows.
        cycle(0, zb, 0, 1, 0);
        for (int r = 0; r < OB_DEPTH; r++) begin
            for (int b = 0; b < BEATS; b++) cycle(1, rnd_beat(), 0, 0, 0);
            cycle(1, rnd_beat(), 0, 0, 0);
            chk("fill_we", s_we, 1);
            chk("fill_idx", s_idx, r);
        end
        cycle(1, rnd_beat(), 1, 0, 0);
        chk("full_flag", s_full, 1);
        chk("full_ready", s_ready, 0);
        chk("full_idx", s_idx, 0);
        chk("full_rows", s_rows, 64);
        cycle(1, rnd_beat(), 0, 0, 0);
        chk("full_no_we", s_we, 0);
        cycle(0, zb, 0, 1, 0);
        cycle(0, zb, 0, 0, 0);
        chk("clr_rows", s_rows, 0);
        chk("clr_full", s_full, 0);
        chk("clr_ready", s_ready, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 4) != 0, rnd_beat(), ($urandom % 16) == 0,
                  ($urandom % 300) == 0, ($urandom % 4) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
